// File: rtl/fpdiv_arbiter.sv
// fpdiv_arbiter: round-robin sharing of one FP divide/sqrt unit across N lanes (FPDIV_ARB_FIXED_PRIO_EN selects fixed priority)
module fpdiv_arbiter #(
  parameter int N = 4,
  parameter int DSTWidth = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N-1:0]            REQ,
  input  logic [N-1:0]            CMD,
  input  logic [3*N-1:0]          SA,
  input  logic [3*N-1:0]          SB,
  input  logic [128*N-1:0]        A,
  input  logic [128*N-1:0]        B,
  input  logic [DSTWidth*N-1:0]   DSTI,
  output logic [N-1:0]            GNT,
  output logic [N-1:0]            RV,
  output logic [127:0]            RR,
  output logic [DSTWidth-1:0]     RDST,
  output logic [2:0]              RSR,
  output logic                    RZERO,
  output logic                    RSIGN,
  output logic                    RINF,
  output logic                    RNAN,
  output logic                    BUSY,
  output logic                    ERR,
  output logic                    D_ACT,
  output logic                    D_CMD,
  output logic [2:0]              D_SA,
  output logic [2:0]              D_SB,
  output logic [127:0]            D_A,
  output logic [127:0]            D_B,
  output logic [DSTWidth+IDW-1:0] D_DSTI,
  input  logic                    D_NEXT,
  input  logic                    D_RDY,
  input  logic [127:0]            D_R,
  input  logic [DSTWidth+IDW-1:0] D_DSTO,
  input  logic [2:0]              D_SR,
  input  logic                    D_ZERO,
  input  logic                    D_SIGN,
  input  logic                    D_INF,
  input  logic                    D_NAN
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_n;
  logic [IDW-1:0] win, cur_id;
  logic done, match, take;
  assign cur_id = D_DSTI[DSTWidth+IDW-1 -: IDW];
  assign done   = state == WAIT && D_RDY;
  assign match  = D_DSTO[DSTWidth+IDW-1 -: IDW] == cur_id;
  // a matched completion frees the divider on the same edge, so it may grant like IDLE does
  assign take   = (state == IDLE || (done && match)) && D_NEXT && |REQ;
  assign D_ACT  = state == ISSUE;
  assign BUSY   = state != IDLE;
`ifdef FPDIV_ARB_FIXED_PRIO_EN
  // lowest-index requester wins
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) if (REQ[i]) win = IDW'(i);
  end
`else
  logic [IDW-1:0] ptr;
  // first requester after the last granted lane, scanning with wrap
  always_comb begin
    win = '0;
    for (int i = N; i >= 1; i--) if (REQ[(int'(ptr) + i) % N]) win = IDW'((int'(ptr) + i) % N);
  end
  // pointer remembers the last granted lane
  always_ff @(posedge CLK) ptr <= RST ? IDW'(N - 1) : take ? win : ptr;
`endif
  // state register
  always_ff @(posedge CLK) state <= RST ? IDLE : state_n;
  // next state: grant -> issue one cycle -> wait for the divider result
  always_comb state_n = take ? ISSUE : state == ISSUE ? WAIT : done ? IDLE : state;
  // operand capture, grant/result pulses and result routing
  always_ff @(posedge CLK)
    if (RST) begin
      GNT <= '0;
      RV <= '0;
      ERR <= 1'b0;
      RR <= '0;
      RDST <= '0;
      RSR <= '0;
      {RZERO, RSIGN, RINF, RNAN} <= '0;
      D_CMD <= 1'b0;
      D_SA <= '0;
      D_SB <= '0;
      D_A <= '0;
      D_B <= '0;
      D_DSTI <= '0;
    end else begin
      GNT <= take ? N'(1) << win : '0;
      RV <= done && match ? N'(1) << cur_id : '0;
      ERR <= D_RDY && !(done && match);
      if (take) begin
        D_CMD <= CMD[win];
        D_SA <= SA[3*win +: 3];
        D_SB <= SB[3*win +: 3];
        D_A <= A[128*win +: 128];
        D_B <= B[128*win +: 128];
        D_DSTI <= {win, DSTI[DSTWidth*win +: DSTWidth]};
      end
      if (done && match) begin
        RR <= D_R;
        RSR <= D_SR;
        RDST <= D_DSTO[DSTWidth-1:0];
        {RZERO, RSIGN, RINF, RNAN} <= {D_ZERO, D_SIGN, D_INF, D_NAN};
      end
    end
endmodule

// File: tb/tb_fpdiv_arbiter.sv
// tb_fpdiv_arbiter: scoreboard bench for fpdiv_arbiter with a scripted divider model
module tb_fpdiv_arbiter;
  localparam int N = 4;
  localparam logic [127:0] Q1_5 = 128'h3FFF_8000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] Q2_0 = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] Q3_0 = 128'h4000_8000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] Q4_0 = 128'h4001_0000_0000_0000_0000_0000_0000_0000;
`ifdef FPDIV_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  typedef struct {
    int lane;
    logic [127:0] rr;
    logic [3:0] rdst;
    logic [3:0] fl;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  logic clk = 0, rst = 1;
  logic [N-1:0] req = '0, cmd = '0;
  logic [3*N-1:0] sa = '0, sbf = '0;
  logic [128*N-1:0] a = '0, b = '0;
  logic [4*N-1:0] dsti = '0;
  logic [N-1:0] gnt, rv;
  logic [127:0] rr, d_a, d_b;
  logic [3:0] rdst;
  logic [2:0] rsr, d_sa, d_sb;
  logic rzero, rsign, rinf, rnan, busy, err, d_act, d_cmd;
  logic [5:0] d_dsti;
  logic d_next = 1, d_rdy = 0, d_zero = 0, d_sign = 0, d_inf = 0, d_nan = 0;
  logic [127:0] d_r = '0;
  logic [5:0] d_dsto = '0;
  logic [2:0] d_sr = 3'b100;
  always #5 clk = ~clk;
  fpdiv_arbiter #(.N(N), .DSTWidth(4)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .CMD(cmd), .SA(sa), .SB(sbf), .A(a), .B(b), .DSTI(dsti),
    .GNT(gnt), .RV(rv), .RR(rr), .RDST(rdst), .RSR(rsr), .RZERO(rzero), .RSIGN(rsign),
    .RINF(rinf), .RNAN(rnan), .BUSY(busy), .ERR(err), .D_ACT(d_act), .D_CMD(d_cmd),
    .D_SA(d_sa), .D_SB(d_sb), .D_A(d_a), .D_B(d_b), .D_DSTI(d_dsti), .D_NEXT(d_next),
    .D_RDY(d_rdy), .D_R(d_r), .D_DSTO(d_dsto), .D_SR(d_sr), .D_ZERO(d_zero), .D_SIGN(d_sign),
    .D_INF(d_inf), .D_NAN(d_nan)
  );
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic set_lane(input int l, input logic c, input logic [127:0] x, input logic [127:0] y, input logic [3:0] d);
    cmd[l] = c;
    sa[3*l +: 3] = 3'b100;
    sbf[3*l +: 3] = 3'b100;
    a[128*l +: 128] = x;
    b[128*l +: 128] = y;
    dsti[4*l +: 4] = d;
  endtask
  task automatic wait_act(input logic [3:0] clr, output logic [3:0] g, output logic [5:0] tag);
    int n = 0;
    while (!d_act && n < 20) begin
      cyc();
      n++;
    end
    if (!d_act) begin
      total++;
      bad++;
      $display("FAIL act_timeout got=%b want=1", d_act);
    end
    g = gnt;
    tag = d_dsti;
    req = req & ~clr;
  endtask
  task automatic reply(input logic [5:0] tag, input logic [127:0] r, input logic [3:0] fl, input logic wrong, input int lat);
    repeat (lat) cyc();
    d_rdy = 1;
    d_r = r;
    d_dsto = wrong ? {tag[5:4] + 2'd1, tag[3:0]} : tag;
    {d_zero, d_sign, d_inf, d_nan} = fl;
    cyc();
    d_rdy = 0;
    {d_zero, d_sign, d_inf, d_nan} = '0;
  endtask
  task automatic test_reset;
    repeat (2) cyc();
    rst = 0;
    cyc();
    total++;
    if ({gnt, rv, busy, err, d_act, rr, rdst, rsr, d_dsti, d_a} !== '0) begin
      bad++;
      $display("FAIL reset got gnt=%b rv=%b busy=%b err=%b act=%b rr=%h want all 0", gnt, rv, busy, err, d_act, rr);
    end
  endtask
  task automatic test_single;
    exp_t e;
    logic [5:0] tag;
    set_lane(2, 1'b0, Q3_0, Q1_5, 4'hA);
    req = 4'b0100;
    sb.push_back('{2, Q2_0, 4'hA, 4'h0});
    cyc();
    total++;
    if ({gnt, d_act} !== {4'b0100, 1'b1}) begin
      bad++;
      $display("FAIL single_gnt got gnt=%b act=%b want 0100 1", gnt, d_act);
    end
    tag = d_dsti;
    req = '0;
    total++;
    if ({tag, d_a, d_b, d_cmd, d_sa, d_sb} !== {2'd2, 4'hA, Q3_0, Q1_5, 1'b0, 3'b100, 3'b100}) begin
      bad++;
      $display("FAIL single_ops got tag=%h a=%h b=%h cmd=%b want tag=2a", tag, d_a, d_b, d_cmd);
    end
    cyc();
    total++;
    if ({d_act, busy, gnt} !== {1'b0, 1'b1, 4'b0}) begin
      bad++;
      $display("FAIL single_act_pulse got act=%b busy=%b gnt=%b want 0 1 0000", d_act, busy, gnt);
    end
    reply(tag, Q2_0, 4'h0, 1'b0, 2);
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL single_sb empty got=0 want=1");
    end else begin
      e = sb.pop_front();
      if ({rv, rr, rdst, rsr, rzero, rsign, rinf, rnan, err} !== {4'(1 << e.lane), e.rr, e.rdst, 3'b100, e.fl, 1'b0}) begin
        bad++;
        $display("FAIL single_result got rv=%b rr=%h rdst=%h rsr=%b err=%b want rv=%b rr=%h rdst=%h", rv, rr, rdst, rsr, err, 4'(1 << e.lane), e.rr, e.rdst);
      end
    end
    cyc();
    total++;
    if ({rv, rr, busy} !== {4'b0, Q2_0, 1'b0}) begin
      bad++;
      $display("FAIL single_hold got rv=%b rr=%h busy=%b want 0000 %h 0", rv, rr, busy, Q2_0);
    end
  endtask
  task automatic test_round_robin;
    exp_t e;
    logic [3:0] g;
    logic [5:0] tag;
    rst = 1;
    cyc();
    rst = 0;
    for (int l = 0; l < N; l++) set_lane(l, 1'b0, Q3_0, Q1_5, 4'(l + 5));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int lane = FIXED ? 0 : i % N;
      wait_act(i == 4 ? 4'hF : 4'h0, g, tag);
      total++;
      if (g !== 4'(1 << lane)) begin
        bad++;
        $display("FAIL rr_order op=%0d got gnt=%b want=%b", i, g, 4'(1 << lane));
      end
      sb.push_back('{lane, 128'(i * 7 + 3), 4'(lane + 5), 4'h0});
      reply(tag, 128'(i * 7 + 3), 4'h0, 1'b0, 2);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rr_sb empty got=0 want=1");
      end else begin
        e = sb.pop_front();
        if ({rv, rr, rdst, rsr, err} !== {4'(1 << e.lane), e.rr, e.rdst, 3'b100, 1'b0}) begin
          bad++;
          $display("FAIL rr_result op=%0d got rv=%b rr=%h rdst=%h want rv=%b rr=%h rdst=%h", i, rv, rr, rdst, 4'(1 << e.lane), e.rr, e.rdst);
        end
      end
    end
  endtask
  task automatic test_bad_tag;
    exp_t e;
    logic [3:0] g;
    logic [5:0] tag;
    cyc();
    set_lane(1, 1'b0, Q3_0, Q1_5, 4'h2);
    req = 4'b0010;
    wait_act(4'b0010, g, tag);
    reply(tag, Q4_0, 4'h0, 1'b1, 3);
    total++;
    if ({err, rv, busy, rr} !== {1'b1, 4'b0, 1'b0, 128'd31}) begin
      bad++;
      $display("FAIL bad_tag got err=%b rv=%b busy=%b rr=%h want 1 0000 0 1f", err, rv, busy, rr);
    end
    set_lane(3, 1'b0, Q3_0, Q1_5, 4'hC);
    req = 4'b1000;
    sb.push_back('{3, Q2_0, 4'hC, 4'b1000});
    wait_act(4'b1000, g, tag);
    total++;
    if (g !== 4'b1000) begin
      bad++;
      $display("FAIL bad_tag_next_gnt got=%b want=1000", g);
    end
    reply(tag, Q2_0, 4'b1000, 1'b0, 1);
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL bad_tag_sb empty got=0 want=1");
    end else begin
      e = sb.pop_front();
      if ({rv, rr, rdst, rsr, rzero, rsign, rinf, rnan, err} !== {4'(1 << e.lane), e.rr, e.rdst, 3'b100, e.fl, 1'b0}) begin
        bad++;
        $display("FAIL bad_tag_recover got rv=%b rr=%h rdst=%h zero=%b err=%b want rv=%b rr=%h rdst=%h", rv, rr, rdst, rzero, err, 4'(1 << e.lane), e.rr, e.rdst);
      end
    end
  endtask
  task automatic test_reset_mid;
    logic [3:0] g;
    logic [5:0] tag;
    set_lane(0, 1'b0, Q3_0, Q1_5, 4'h7);
    req = 4'b0001;
    wait_act(4'b0001, g, tag);
    repeat (2) cyc();
    rst = 1;
    cyc();
    rst = 0;
    total++;
    if ({gnt, rv, busy, err, d_act, rr, rdst, rsr, rzero, rsign, rinf, rnan, d_cmd, d_sa, d_sb, d_a, d_b, d_dsti} !== '0) begin
      bad++;
      $display("FAIL reset_mid got gnt=%b rv=%b busy=%b rr=%h dsti=%h d_a=%h want all 0", gnt, rv, busy, rr, d_dsti, d_a);
    end
    reply(tag, Q2_0, 4'h0, 1'b0, 0);
    total++;
    if ({err, rv, rr} !== {1'b1, 4'b0, 128'b0}) begin
      bad++;
      $display("FAIL idle_rdy got err=%b rv=%b rr=%h want 1 0000 0", err, rv, rr);
    end
    cyc();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse got=%b want=0", err);
    end
  endtask
  task automatic test_dnext;
    exp_t e;
    logic seen = 1'b0;
    logic [5:0] tag;
    set_lane(1, 1'b0, Q3_0, Q1_5, 4'h6);
    d_next = 0;
    req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      cyc();
      seen = seen | (|gnt) | busy;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL dnext_stall got grant_or_busy=%b want=0", seen);
    end
    d_next = 1;
    cyc();
    total++;
    if ({gnt, d_act} !== {4'b0010, 1'b1}) begin
      bad++;
      $display("FAIL dnext_gnt got gnt=%b act=%b want 0010 1", gnt, d_act);
    end
    tag = d_dsti;
    req = '0;
    sb.push_back('{1, Q2_0, 4'h6, 4'h0});
    reply(tag, Q2_0, 4'h0, 1'b0, 1);
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL dnext_sb empty got=0 want=1");
    end else begin
      e = sb.pop_front();
      if ({rv, rr, rdst} !== {4'(1 << e.lane), e.rr, e.rdst}) begin
        bad++;
        $display("FAIL dnext_result got rv=%b rr=%h rdst=%h want rv=%b rr=%h rdst=%h", rv, rr, rdst, 4'(1 << e.lane), e.rr, e.rdst);
      end
    end
  endtask
  task automatic test_back_to_back;
    exp_t e;
    logic [3:0] g;
    logic [5:0] tag;
    cyc();
    set_lane(0, 1'b1, '0, Q4_0, 4'h9);
    set_lane(1, 1'b0, Q3_0, Q1_5, 4'h3);
    req = 4'b0011;
    wait_act(4'b0001, g, tag);
    total++;
    if ({g, d_cmd, d_b, tag} !== {4'b0001, 1'b1, Q4_0, 2'd0, 4'h9}) begin
      bad++;
      $display("FAIL b2b_issue got gnt=%b cmd=%b b=%h tag=%h want 0001 1 %h 09", g, d_cmd, d_b, tag, Q4_0);
    end
    sb.push_back('{0, Q2_0, 4'h9, 4'h0});
    reply(tag, Q2_0, 4'h0, 1'b0, 2);
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL b2b_sb empty got=0 want=1");
    end else begin
      e = sb.pop_front();
      if ({rv, rr, rdst, gnt, d_act} !== {4'(1 << e.lane), e.rr, e.rdst, 4'b0010, 1'b1}) begin
        bad++;
        $display("FAIL b2b_overlap got rv=%b rr=%h rdst=%h gnt=%b act=%b want rv=0001 rr=%h rdst=9 gnt=0010 act=1", rv, rr, rdst, gnt, d_act, e.rr);
      end
    end
    wait_act(4'b0010, g, tag);
    sb.push_back('{1, Q2_0, 4'h3, 4'b0101});
    reply(tag, Q2_0, 4'b0101, 1'b0, 1);
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL b2b_sb2 empty got=0 want=1");
    end else begin
      e = sb.pop_front();
      if ({rv, rr, rdst, rzero, rsign, rinf, rnan} !== {4'(1 << e.lane), e.rr, e.rdst, e.fl}) begin
        bad++;
        $display("FAIL b2b_second got rv=%b rr=%h rdst=%h fl=%b want rv=%b rdst=%h fl=%b", rv, rr, rdst, {rzero, rsign, rinf, rnan}, 4'(1 << e.lane), e.rdst, e.fl);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_bad_tag();
    test_reset_mid();
    test_dnext();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
